dcache_dm_wt: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the CPU data port and the shared word memory.
- Data port is 16-bit; each line holds 4 words.
- Read hits complete combinationally in the same cycle. Misses fetch a whole line from memory in one burst.
- Hit and miss counters are exported for the bench to measure cache effectiveness.

---
 rtl/dcache_dm_wt.sv | 127 ++++++++++++
 tb/tb_dcache_dm_wt.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dcache_dm_wt.sv
// Purpose : direct-mapped, write-through, no-write-allocate data cache, 4 words/line.
// Latency : read hit 0 cycles (combinational c_ready); read miss / any write = 1 cycle + memory latency.
// Backpr. : CPU request is held until c_ready; memory request is held until the m_ready pulse.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   c_read/c_write/c_addr/c_wdata -> c_rdata/c_ready   CPU data port
//   m_read/m_write/m_addr/m_wdata <- m_rdata/m_ready   shared word memory (line reads, word writes)
//   num_hit/num_miss        wrapping 16-bit effectiveness counters
module dcache_dm_wt #(
    parameter int WORD_SIZE = 16,
    parameter int NUM_LINES = 4,
    parameter int IDX_W     = $clog2(NUM_LINES)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   c_read,
    input  logic                   c_write,
    input  logic [WORD_SIZE-1:0]   c_addr,
    input  logic [WORD_SIZE-1:0]   c_wdata,
    output logic [WORD_SIZE-1:0]   c_rdata,
    output logic                   c_ready,
    output logic                   m_read,
    output logic                   m_write,
    output logic [WORD_SIZE-1:0]   m_addr,
    output logic [WORD_SIZE-1:0]   m_wdata,
    input  logic [4*WORD_SIZE-1:0] m_rdata,
    input  logic                   m_ready,
    output logic [15:0]            num_hit,
    output logic [15:0]            num_miss
);

    localparam int TAG_W = WORD_SIZE - 2 - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [NUM_LINES-1:0]   r_valid;
    logic [TAG_W-1:0]       r_tag  [NUM_LINES];
    logic [WORD_SIZE-1:0]   r_data [NUM_LINES][4];
    logic [15:0]            r_num_hit;
    logic [15:0]            r_num_miss;

    logic [1:0]             w_off;
    logic [IDX_W-1:0]       w_idx;
    logic [TAG_W-1:0]       w_tag;
    logic                   w_hit;
    logic [WORD_SIZE-1:0]   w_line [4];
    logic                   w_fill;
    logic                   w_wr_done;

    assign w_off = c_addr[1:0];
    assign w_idx = c_addr[2 +: IDX_W];
    assign w_tag = c_addr[WORD_SIZE-1 -: TAG_W];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // Unpack the fetched line: word0 sits in the low bits.
    for (genvar k = 0; k < 4; k++) begin : g_line
        assign w_line[k] = m_rdata[k*WORD_SIZE +: WORD_SIZE];
    end

    assign w_fill    = (r_state == S_FETCH) && m_ready;
    assign w_wr_done = (r_state == S_WRITE) && m_ready;

    // Outputs are gated with reset_n so they drop in the same timestep reset asserts.
    assign c_ready = reset_n && (((r_state == S_IDLE) && c_read && !c_write && w_hit)
                                 || w_fill || w_wr_done);
    // During a fill the requested word is forwarded straight from memory.
    assign c_rdata = (r_state == S_FETCH) ? w_line[w_off] : r_data[w_idx][w_off];
    assign m_read  = reset_n && (r_state == S_FETCH);
    assign m_write = reset_n && (r_state == S_WRITE);
    assign m_addr  = (r_state == S_FETCH) ? {c_addr[WORD_SIZE-1:2], 2'b00} : c_addr;
    assign m_wdata = c_wdata;

    assign num_hit  = r_num_hit;
    assign num_miss = r_num_miss;

    // Control state: FSM, valid bits and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_num_hit  <= '0;
            r_num_miss <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (c_write || c_read) begin
                        if (w_hit) r_num_hit  <= r_num_hit + 16'd1;
                        else       r_num_miss <= r_num_miss + 16'd1;
                    end
                    // Write wins when both requests are raised together.
                    if (c_write)                r_state <= S_WRITE;
                    else if (c_read && !w_hit)  r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (m_ready) begin
                        r_valid[w_idx] <= 1'b1;
                        r_state        <= S_IDLE;
                    end
                end
                S_WRITE: begin
                    if (m_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Line storage needs no reset: it is only observable through a set valid bit.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_idx] <= w_tag;
            for (int k = 0; k < 4; k++) begin
                r_data[w_idx][k] <= w_line[k];
            end
        end else if (w_wr_done && w_hit) begin
            // Write-through update of a resident line; misses leave the cache untouched.
            r_data[w_idx][w_off] <= c_wdata;
        end
    end

endmodule

// File: tb/tb_dcache_dm_wt.sv
module tb_dcache_dm_wt;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        c_read = 1'b0;
    logic        c_write = 1'b0;
    logic [15:0] c_addr = '0;
    logic [15:0] c_wdata = '0;
    logic [15:0] c_rdata;
    logic        c_ready;
    logic        m_read;
    logic        m_write;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [63:0] m_rdata = '0;
    logic        m_ready = 1'b0;
    logic [15:0] num_hit;
    logic [15:0] num_miss;

    dcache_dm_wt #(.WORD_SIZE(16), .NUM_LINES(4), .IDX_W(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .c_read(c_read), .c_write(c_write), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_rdata(c_rdata), .c_ready(c_ready),
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .num_hit(num_hit), .num_miss(num_miss)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd;
        logic [15:0] dat;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          eh = 0;
    int          em = 0;
    logic [15:0] mem [0:255];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    // Memory model: acknowledges each request on its second cycle, write applied at ack.
    initial begin
        int         cnt;
        logic [7:0] a;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            m_ready = 1'b0;
            if (reset_n && (m_read || m_write)) begin
                cnt++;
                if (cnt == 2) begin
                    a = m_addr[7:0];
                    if (m_write) mem[a] = m_wdata;
                    else m_rdata = {mem[{a[7:2], 2'd3}], mem[{a[7:2], 2'd2}],
                                    mem[{a[7:2], 2'd1}], mem[{a[7:2], 2'd0}]};
                    m_ready = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: every completion pops the oldest expectation.
    always @(negedge clk) begin
        if (c_ready) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_c_ready: got c_ready=1 with no request outstanding");
            end else begin
                mon_e = q.pop_front();
                if (mon_e.rd) chk("c_rdata", 64'(c_rdata), 64'(mon_e.dat));
                else          chk("write_done_m_write", 64'(m_write), 64'd1);
            end
        end
    end

    // Issue one CPU request and check memory traffic and counters afterwards.
    // exp_mem: 0 = no memory access, 1 = line read, 2 = word write.
    task automatic req(input string tag, input logic wr, input logic rd_too,
                       input logic [15:0] addr, input logic [15:0] wd,
                       input logic [15:0] exp_rd, input logic exp_hit,
                       input logic [1:0] exp_mem, input logic [15:0] exp_maddr);
        logic        saw_rd, saw_wr, saw_both, done;
        logic [15:0] ma, mwd;
        saw_rd = 0; saw_wr = 0; saw_both = 0; done = 0; ma = '0; mwd = '0;
        q.push_back('{rd: !wr, dat: exp_rd});
        c_addr  = addr;
        c_wdata = wd;
        c_write = wr;
        c_read  = !wr || rd_too;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            @(negedge clk);
            if (m_read)  begin saw_rd = 1; ma = m_addr; end
            if (m_write) begin saw_wr = 1; ma = m_addr; mwd = m_wdata; end
            if (m_read && m_write) saw_both = 1;
            if (c_ready) done = 1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no c_ready in 40 cycles, expected completion", tag);
            finish_run();
        end
        @(posedge clk);
        #1;
        c_read  = 0;
        c_write = 0;
        if (exp_hit) eh++; else em++;
        chk({tag, "_num_hit"},  64'(num_hit),  64'(eh));
        chk({tag, "_num_miss"}, 64'(num_miss), 64'(em));
        chk({tag, "_m_read_seen"},  64'(saw_rd), 64'(exp_mem == 2'd1));
        chk({tag, "_m_write_seen"}, 64'(saw_wr), 64'(exp_mem == 2'd2));
        chk({tag, "_rd_wr_overlap"}, 64'(saw_both), 64'd0);
        if (exp_mem != 2'd0) chk({tag, "_m_addr"}, 64'(ma), 64'(exp_maddr));
        if (exp_mem == 2'd2) chk({tag, "_m_wdata"}, 64'(mwd), 64'(wd));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'hA000 + 16'(i);
        mem[8'h10] = 16'h1111;
        mem[8'h11] = 16'h2222;
        mem[8'h12] = 16'h3333;
        mem[8'h13] = 16'h4444;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_num_hit",  64'(num_hit),  64'd0);
        chk("reset_num_miss", 64'(num_miss), 64'd0);
        chk("reset_c_ready",  64'(c_ready),  64'd0);
        chk("reset_m_read",   64'(m_read),   64'd0);
        chk("reset_m_write",  64'(m_write),  64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        //   tag        wr rd  addr      wdata     exp_rd    hit mem addr
        req("cold_miss",  0, 0, 16'h0011, 16'h0000, 16'h2222, 0, 1, 16'h0010);
        req("read_hit",   0, 0, 16'h0013, 16'h0000, 16'h4444, 1, 0, 16'h0000);
        req("conflict_a", 0, 0, 16'h0020, 16'h0000, 16'hA020, 0, 1, 16'h0020);
        req("conflict_b", 0, 0, 16'h0010, 16'h0000, 16'h1111, 0, 1, 16'h0010);
        req("write_hit",  1, 0, 16'h0012, 16'hBEEF, 16'h0000, 1, 2, 16'h0012);
        req("rd_after_wr",0, 0, 16'h0012, 16'h0000, 16'hBEEF, 1, 0, 16'h0000);
        req("write_miss", 1, 0, 16'h0044, 16'h5555, 16'h0000, 0, 2, 16'h0044);
        req("rd_wr_miss", 0, 0, 16'h0044, 16'h0000, 16'h5555, 0, 1, 16'h0044);
        req("hit_off2",   0, 0, 16'h0046, 16'h0000, 16'hA046, 1, 0, 16'h0000);
        // Write and read together: write wins; index 1 holds tag 4, so this misses.
        req("wr_prio",    1, 1, 16'h0024, 16'h7777, 16'h0000, 0, 2, 16'h0024);
        req("no_alloc",   0, 0, 16'h0044, 16'h0000, 16'h5555, 1, 0, 16'h0000);

        // Reset in the middle of a fetch (index 0 holds line 0x10, so 0x21 misses).
        c_addr = 16'h0021;
        c_read = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_reset_m_read", 64'(m_read), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rst_m_read",   64'(m_read),   64'd0);
        chk("rst_c_ready",  64'(c_ready),  64'd0);
        chk("rst_num_hit",  64'(num_hit),  64'd0);
        chk("rst_num_miss", 64'(num_miss), 64'd0);
        c_read = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        eh = 0;
        em = 0;
        req("post_reset", 0, 0, 16'h0013, 16'h0000, 16'h4444, 0, 1, 16'h0010);

        repeat (3) @(posedge clk);
        finish_run();
    end

endmodule
